// File: rtl/decode_stage.sv
// decode_stage: single-cycle registered RISC-V RV32I/RV32E instruction decoder with valid/ready handshake.
// Rev 1.0
`default_nettype none

module decode_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       inst,
  input  logic [XLEN-1:0]   pc_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [6:0]        opcode,
  output logic [REG_AW-1:0] rd,
  output logic [REG_AW-1:0] rs1,
  output logic [REG_AW-1:0] rs2,
  output logic [3:0]        alu_func,
  output logic [XLEN-1:0]   imm,
  output logic [2:0]        fmt,
  output logic [XLEN-1:0]   pc_out,
  output logic              illegal,
  output logic [CNT_W-1:0]  dec_cnt
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4, FMT_J = 3'd5, FMT_NONE = 3'd7;

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic        dec_ok, use_rd, use_rs1, use_rs2, rv32e_bad, legal;
  logic [2:0]  raw_fmt;
  logic [3:0]  raw_alu;
  logic [31:0] imm32;

  logic [6:0]        opcode_d, opcode_q;
  logic [REG_AW-1:0] rd_d, rd_q, rs1_d, rs1_q, rs2_d, rs2_q;
  logic [3:0]        alu_func_d, alu_func_q;
  logic [XLEN-1:0]   imm_d, imm_q, pc_out_d, pc_out_q;
  logic [2:0]        fmt_d, fmt_q;
  logic              illegal_d, illegal_q, out_valid_d, out_valid_q;
  logic [CNT_W-1:0]  dec_cnt_d, dec_cnt_q;
  logic [6:0]        dec_opcode;
  logic [REG_AW-1:0] dec_rd, dec_rs1, dec_rs2;
  logic [3:0]        dec_alu;
  logic [XLEN-1:0]   dec_imm;
  logic [2:0]        dec_fmt;
  logic              accept;

  assign opc = inst[6:0];
  assign f3  = inst[14:12];
  assign f7  = inst[31:25];

  always_comb begin
    dec_ok  = 1'b0;
    raw_fmt = FMT_NONE;
    raw_alu = 4'd0;
    imm32   = 32'd0;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    if (inst[1:0] == 2'b11) begin
      case (opc)
        OPC_OP: begin
          dec_ok  = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
          raw_fmt = FMT_R;
          raw_alu = {inst[30], f3};
          {use_rd, use_rs1, use_rs2} = 3'b111;
        end
        OPC_OPIMM, OPC_LOAD, OPC_JALR: begin
          if (opc == OPC_OPIMM)
            dec_ok = (f3 == 3'b001) ? (f7 == 7'h00) :
                     (f3 == 3'b101) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
          else if (opc == OPC_LOAD)
            dec_ok = !(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
          else
            dec_ok = (f3 == 3'b000);
          raw_fmt = FMT_I;
          // Only the OP-IMM right shifts carry an arithmetic/logical select in bit 30.
          raw_alu = {(opc == OPC_OPIMM) && (f3 == 3'b101) && inst[30], f3};
          imm32   = {{20{inst[31]}}, inst[31:20]};
          {use_rd, use_rs1} = 2'b11;
        end
        OPC_STORE: begin
          dec_ok  = (f3 <= 3'b010);
          raw_fmt = FMT_S;
          raw_alu = {1'b0, f3};
          imm32   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
          {use_rs1, use_rs2} = 2'b11;
        end
        OPC_BRANCH: begin
          dec_ok  = !(f3 == 3'b010 || f3 == 3'b011);
          raw_fmt = FMT_B;
          raw_alu = {1'b0, f3};
          imm32   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
          {use_rs1, use_rs2} = 2'b11;
        end
        OPC_LUI, OPC_AUIPC: begin
          dec_ok  = 1'b1;
          raw_fmt = FMT_U;
          imm32   = {inst[31:12], 12'd0};
          use_rd  = 1'b1;
        end
        OPC_JAL: begin
          dec_ok  = 1'b1;
          raw_fmt = FMT_J;
          imm32   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
          use_rd  = 1'b1;
        end
        default: dec_ok = 1'b0;
      endcase
    end
  end

  // RV32E only has x0..x15, so a used register field with bit 4 set is illegal.
  assign rv32e_bad = (REG_AW == 4) &&
                     ((use_rd && inst[11]) || (use_rs1 && inst[19]) || (use_rs2 && inst[24]));
  assign legal     = dec_ok && !rv32e_bad;

  assign dec_opcode = legal ? opc : 7'd0;
  assign dec_rd     = (legal && use_rd)  ? inst[7 +: REG_AW]  : '0;
  assign dec_rs1    = (legal && use_rs1) ? inst[15 +: REG_AW] : '0;
  assign dec_rs2    = (legal && use_rs2) ? inst[20 +: REG_AW] : '0;
  assign dec_alu    = legal ? raw_alu : 4'd0;
  assign dec_imm    = legal ? XLEN'($signed(imm32)) : '0;
  assign dec_fmt    = legal ? raw_fmt : FMT_NONE;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    out_valid_d = out_valid_q;
    dec_cnt_d   = dec_cnt_q;
    opcode_d    = opcode_q;
    rd_d        = rd_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    alu_func_d  = alu_func_q;
    imm_d       = imm_q;
    fmt_d       = fmt_q;
    illegal_d   = illegal_q;
    pc_out_d    = pc_out_q;
    if (accept) begin
      out_valid_d = 1'b1;
      dec_cnt_d   = dec_cnt_q + CNT_W'(1);
      opcode_d    = dec_opcode;
      rd_d        = dec_rd;
      rs1_d       = dec_rs1;
      rs2_d       = dec_rs2;
      alu_func_d  = dec_alu;
      imm_d       = dec_imm;
      fmt_d       = dec_fmt;
      illegal_d   = !legal;
      pc_out_d    = pc_in;
    end else if (flush || out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      dec_cnt_q   <= '0;
      opcode_q    <= 7'd0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      alu_func_q  <= 4'd0;
      imm_q       <= '0;
      fmt_q       <= FMT_NONE;
      illegal_q   <= 1'b0;
      pc_out_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      dec_cnt_q   <= dec_cnt_d;
      opcode_q    <= opcode_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      alu_func_q  <= alu_func_d;
      imm_q       <= imm_d;
      fmt_q       <= fmt_d;
      illegal_q   <= illegal_d;
      pc_out_q    <= pc_out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dec_cnt   = dec_cnt_q;
  assign opcode    = opcode_q;
  assign rd        = rd_q;
  assign rs1       = rs1_q;
  assign rs2       = rs2_q;
  assign alu_func  = alu_func_q;
  assign imm       = imm_q;
  assign fmt       = fmt_q;
  assign illegal   = illegal_q;
  assign pc_out    = pc_out_q;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and random checks of decode_stage (RV32I and RV32E instances) against a reference model.
`default_nettype none

module tb_decode_stage;

  typedef struct {
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [3:0]  alu;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        illegal;
  } dec_t;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, flush, out_ready;
  logic [31:0] inst, pc_in;

  logic        in_ready, out_valid, illegal;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [3:0]  alu_func;
  logic [31:0] imm, pc_out;
  logic [2:0]  fmt;
  logic [3:0]  dec_cnt;

  logic        in_ready_e, out_valid_e, illegal_e;
  logic [6:0]  opcode_e;
  logic [3:0]  rd_e, rs1_e, rs2_e;
  logic [3:0]  alu_func_e;
  logic [31:0] imm_e, pc_out_e;
  logic [2:0]  fmt_e;
  logic [15:0] dec_cnt_e;

  int   n_assert = 0;
  int   n_fail   = 0;
  bit   m_valid  = 0;
  bit   m_fresh  = 0;
  int   m_cnt    = 0;
  dec_t m_d5, m_d4;
  logic [31:0] m_pc;
  logic [15:0] cnt_before;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .REG_AW(5), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
    .pc_in(pc_in), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .alu_func(alu_func), .imm(imm),
    .fmt(fmt), .pc_out(pc_out), .illegal(illegal), .dec_cnt(dec_cnt));

  decode_stage #(.XLEN(32), .REG_AW(4), .CNT_W(16)) dut_e (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_e), .inst(inst),
    .pc_in(pc_in), .flush(flush), .out_valid(out_valid_e), .out_ready(out_ready),
    .opcode(opcode_e), .rd(rd_e), .rs1(rs1_e), .rs2(rs2_e), .alu_func(alu_func_e), .imm(imm_e),
    .fmt(fmt_e), .pc_out(pc_out_e), .illegal(illegal_e), .dec_cnt(dec_cnt_e));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic dec_t zero_dec(input bit ill);
    dec_t d;
    d.opcode = 0; d.rd = 0; d.rs1 = 0; d.rs2 = 0; d.alu = 0; d.imm = 0;
    d.fmt = 3'd7; d.illegal = ill;
    return d;
  endfunction

  // Reference decoder: format table lookup, field usage by format, immediates by arithmetic.
  function automatic dec_t ref_decode(input logic [31:0] i, input int aw);
    dec_t d;
    int   s, f3, f7, op, f, rdf, rs1f, rs2f, mask;
    bit   ok, u_rd, u_rs1, u_rs2;
    s  = $signed(i);
    op = int'(i & 32'h7F);
    f3 = int'((i >> 12) & 7);
    f7 = int'(i >> 25);
    ok = 0; f = 7;
    case (op)
      'h33: begin ok = (f7 == 0) || (f7 == 'h20 && (f3 == 0 || f3 == 5)); f = 0; end
      'h13: begin ok = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 'h20) : 1; f = 1; end
      'h03: begin ok = !(f3 inside {3, 6, 7}); f = 1; end
      'h67: begin ok = (f3 == 0); f = 1; end
      'h23: begin ok = (f3 <= 2); f = 2; end
      'h63: begin ok = !(f3 inside {2, 3}); f = 3; end
      'h37, 'h17: begin ok = 1; f = 4; end
      'h6F: begin ok = 1; f = 5; end
      default: ok = 0;
    endcase
    u_rd  = f inside {0, 1, 4, 5};
    u_rs1 = f inside {0, 1, 2, 3};
    u_rs2 = f inside {0, 2, 3};
    rdf   = int'((i >> 7) & 31);
    rs1f  = int'((i >> 15) & 31);
    rs2f  = int'((i >> 20) & 31);
    if (aw == 4 && ((u_rd && rdf >= 16) || (u_rs1 && rs1f >= 16) || (u_rs2 && rs2f >= 16))) ok = 0;
    if (!ok) return zero_dec(1'b1);
    mask     = (1 << aw) - 1;
    d.opcode = 7'(op);
    d.fmt    = 3'(f);
    d.illegal = 0;
    d.rd  = u_rd  ? 5'(rdf & mask)  : 5'd0;
    d.rs1 = u_rs1 ? 5'(rs1f & mask) : 5'd0;
    d.rs2 = u_rs2 ? 5'(rs2f & mask) : 5'd0;
    if (f == 0 || (op == 'h13 && f3 == 5)) d.alu = 4'(((f7 >> 5) & 1) * 8 + f3);
    else if (f inside {1, 2, 3})           d.alu = 4'(f3);
    else                                   d.alu = 4'd0;
    case (f)
      1: d.imm = 32'(s >>> 20);
      2: d.imm = 32'(((s >>> 25) << 5) | int'((i >> 7) & 31));
      3: d.imm = 32'(((s >>> 31) << 12) | int'(((i >> 7) & 1) << 11) |
                     int'(((i >> 25) & 63) << 5) | int'(((i >> 8) & 15) << 1));
      4: d.imm = i & 32'hFFFFF000;
      5: d.imm = 32'(((s >>> 31) << 20) | int'(((i >> 12) & 255) << 12) |
                     int'(((i >> 20) & 1) << 11) | int'(((i >> 21) & 1023) << 1));
      default: d.imm = 32'd0;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] i;
    logic [6:0]  ops [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h00};
    int k;
    i = $urandom;
    k = int'($urandom_range(0, 10));
    if (k < 10) i[6:0] = ops[k];
    if ($urandom_range(0, 1) == 1 && (i[6:0] == 7'h33 || i[6:0] == 7'h13))
      i[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    return i;
  endfunction

  // Advances one clock: checks in_ready before the edge, updates the model, checks outputs after.
  task automatic step();
    bit exp_ready;
    #1;
    exp_ready = !m_valid || out_ready;
    if (rst_n) begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, exp_ready});
      chk("in_ready_e", {63'd0, in_ready_e}, {63'd0, exp_ready});
    end
    m_fresh = 0;
    if (!rst_n) begin
      m_valid = 0; m_cnt = 0; m_pc = 0; m_fresh = 1;
      m_d5 = zero_dec(1'b0); m_d4 = zero_dec(1'b0);
    end else if (in_valid && exp_ready && !flush) begin
      m_valid = 1; m_cnt++; m_pc = pc_in;
      m_d5 = ref_decode(inst, 5); m_d4 = ref_decode(inst, 4);
    end else if (flush || out_ready) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
    chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
    chk("out_valid_e", {63'd0, out_valid_e}, {63'd0, m_valid});
    chk("dec_cnt", {60'd0, dec_cnt}, 64'(m_cnt % 16));
    chk("dec_cnt_e", {48'd0, dec_cnt_e}, 64'(m_cnt % 65536));
    if (m_valid || m_fresh) begin
      chk("fields", {opcode, rd, rs1, rs2, alu_func, fmt, illegal, imm},
          {m_d5.opcode, m_d5.rd, m_d5.rs1, m_d5.rs2, m_d5.alu, m_d5.fmt, m_d5.illegal, m_d5.imm});
      chk("fields_e", {opcode_e, 1'b0, rd_e, 1'b0, rs1_e, 1'b0, rs2_e, alu_func_e, fmt_e, illegal_e, imm_e},
          {m_d4.opcode, m_d4.rd, m_d4.rs1, m_d4.rs2, m_d4.alu, m_d4.fmt, m_d4.illegal, m_d4.imm});
      chk("pc_out", {32'd0, pc_out}, {32'd0, m_pc});
      chk("pc_out_e", {32'd0, pc_out_e}, {32'd0, m_pc});
    end
  endtask

  task automatic drive(input logic v, input logic r, input logic f, input logic [31:0] i, input logic [31:0] pc);
    in_valid = v; out_ready = r; flush = f; inst = i; pc_in = pc;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    step(); step();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_dec_cnt", {60'd0, dec_cnt}, 64'd0);
    chk("rst_fmt_ill", {60'd0, fmt, illegal}, {60'd0, 3'd7, 1'b0});
    chk("rst_imm_pc", {imm, pc_out}, 64'd0);

    rst_n = 1'b1;
    step();
    chk("in_ready_after_rst", {63'd0, in_ready}, 64'd1);

    drive(1'b1, 1'b1, 1'b0, 32'h00A30293, 32'h0000_0100);
    step();
    chk("addi_valid_fmt", {60'd0, out_valid, fmt}, {60'd0, 1'b1, 3'd1});
    chk("addi_rd_rs1", {54'd0, rd, rs1}, {54'd0, 5'd5, 5'd6});
    chk("addi_imm_alu", {28'd0, alu_func, imm}, {28'd0, 4'b0000, 32'd10});

    drive(1'b1, 1'b1, 1'b0, 32'hFE000EE3, 32'h0000_0104);
    step();
    chk("beq_fmt_rd", {56'd0, fmt, rd}, {56'd0, 3'd3, 5'd0});
    chk("beq_imm", {32'd0, imm}, {32'd0, 32'hFFFFFFFC});

    drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
    step();
    cnt_before = {12'd0, dec_cnt};
    drive(1'b1, 1'b0, 1'b0, 32'h40208833, 32'h0000_0200);
    step();
    for (int c = 0; c < 2; c++) begin
      inst = 32'h00100093 + 32'(c);
      step();
      chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
    end
    chk("stall_cnt_once", {60'd0, dec_cnt}, 64'((cnt_before + 16'd1) % 16));

    drive(1'b1, 1'b1, 1'b0, 32'h00000000, 32'h0000_0300);
    step();
    chk("zero_inst_ill_fmt", {60'd0, illegal, fmt}, {60'd0, 1'b1, 3'd7});

    drive(1'b1, 1'b1, 1'b0, 32'h00208833, 32'h0000_0304);
    step();
    chk("rv32e_x16_ill_fmt", {60'd0, illegal_e, fmt_e}, {60'd0, 1'b1, 3'd7});
    chk("rv32i_x16_rd", {59'd0, illegal, rd}, {59'd0, 1'b0, 5'd16});

    cnt_before = {12'd0, dec_cnt};
    drive(1'b1, 1'b1, 1'b1, 32'h00A30293, 32'h0000_0308);
    step();
    chk("flush_valid_cnt", {59'd0, out_valid, dec_cnt}, {59'd0, 1'b0, cnt_before[3:0]});

    drive(1'b1, 1'b1, 1'b0, 32'h00A30293, 32'h0000_0400);
    for (int c = 0; c < 20 && (m_cnt % 16) != 15; c++) step();
    chk("cnt_at_max", {60'd0, dec_cnt}, 64'd15);
    step();
    chk("cnt_wrap", {60'd0, dec_cnt}, 64'd0);

    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
            rand_inst(), $urandom);
      step();
    end

    drive(1'b1, 1'b1, 1'b0, 32'h00A30293, 32'h0000_0500);
    step();
    drive(1'b1, 1'b0, 1'b0, 32'h00B30293, 32'h0000_0504);
    step();
    rst_n = 1'b0;
    step();
    chk("rst_mid_valid_cnt", {59'd0, out_valid, dec_cnt}, 64'd0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    chk("in_ready_rst_release", {63'd0, in_ready}, 64'd1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
